// File: rtl/hilo_md_ctrl_if.sv
// Request/response bundle between the execute stage and the HI/LO multiply/divide sequencer.
// The pipeline side drives the master modport and the sequencer uses the slave modport.
interface hilo_md_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic                   start;
    logic [2:0]             op;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic [2*WIDTH-1:0]     hilo_i;
    logic                   flush;
    logic                   busy;
    logic                   result_valid;
    logic [2*WIDTH-1:0]     hilo_wd;
    logic                   div_zero;

    modport master (
        output start, op, a, b, hilo_i, flush,
        input  busy, result_valid, hilo_wd, div_zero
    );

    modport slave (
        input  start, op, a, b, hilo_i, flush,
        output busy, result_valid, hilo_wd, div_zero
    );
endinterface

// File: rtl/hilo_md_ctrl.sv
// HI/LO multiply/divide sequencer: owns every {hi,lo} write from MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Division is a WIDTH-step radix-2 restoring loop that stalls the pipeline while it runs.
// Build option MDU_ITER_MULT_EN: multiplies reuse the divide counter and adder as a WIDTH-step
// shift-add loop; otherwise the product is formed in one cycle at accept.
module hilo_md_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    hilo_md_ctrl_if.slave md_io
);
    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    // rem: partial remainder / product high half; quo: quotient / multiplier and product low half
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    // dvs: divisor magnitude, or multiplicand magnitude in the iterative multiply
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;
    logic [2*WIDTH-1:0]   hilo_wd_q, hilo_wd_d;
    logic                 div_zero_q, div_zero_d;

    // Request decode
    logic                 op_mul, op_div, op_mt, op_signed, accept;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   mt_merge;

    assign op_mul    = (md_io.op[2:1] == 2'b10);
    assign op_div    = (md_io.op[2:1] == 2'b11);
    assign op_mt     = (md_io.op[2:1] == 2'b01);
    assign op_signed = ~md_io.op[0];
    assign accept    = md_io.start & (state_q == StIdle) & ~md_io.flush &
                       (op_mul | op_div | op_mt);
    assign a_mag     = (op_signed & md_io.a[WIDTH-1]) ? -md_io.a : md_io.a;
    assign b_mag     = (op_signed & md_io.b[WIDTH-1]) ? -md_io.b : md_io.b;
    // op[0] clear selects MTHI (replace hi), set selects MTLO (replace lo)
    assign mt_merge  = md_io.op[0] ? {md_io.hilo_i[2*WIDTH-1:WIDTH], md_io.a}
                                   : {md_io.a, md_io.hilo_i[WIDTH-1:0]};

    // Shared adder: subtract for a divide step, add for a multiply step
    logic [WIDTH:0]       add_lhs, add_rhs;
    logic                 add_cin;
    logic [WIDTH+1:0]     add_sum;

    // Adder operand select
    always_comb begin
        add_lhs = {rem_q, quo_q[WIDTH-1]};
        add_rhs = ~{1'b0, dvs_q};
        add_cin = 1'b1;
`ifdef MDU_ITER_MULT_EN
        if (state_q == StMul) begin
            add_lhs = {1'b0, rem_q};
            add_rhs = {1'b0, dvs_q};
            add_cin = 1'b0;
        end
`endif
        add_sum = {1'b0, add_lhs} + {1'b0, add_rhs} + {{(WIDTH+1){1'b0}}, add_cin};
    end

    // Restoring divide step: carry out means the shifted remainder covered the divisor
    logic                 no_borrow;
    logic [WIDTH-1:0]     div_rem_nx, div_quo_nx, div_lo, div_hi;

    assign no_borrow  = add_sum[WIDTH+1];
    assign div_rem_nx = no_borrow ? add_sum[WIDTH-1:0] : add_lhs[WIDTH-1:0];
    assign div_quo_nx = {quo_q[WIDTH-2:0], no_borrow};
    assign div_lo     = qneg_q ? -div_quo_nx : div_quo_nx;
    assign div_hi     = rneg_q ? -div_rem_nx : div_rem_nx;

`ifdef MDU_ITER_MULT_EN
    // Shift-add step: conditionally add multiplicand, then shift {hi,lo} right by one
    logic [WIDTH:0]       mul_hi;
    logic [WIDTH-1:0]     mul_rem_nx, mul_quo_nx;
    logic [2*WIDTH-1:0]   mul_mag, mul_fix;

    assign mul_hi     = quo_q[0] ? add_sum[WIDTH:0] : {1'b0, rem_q};
    assign mul_rem_nx = mul_hi[WIDTH:1];
    assign mul_quo_nx = {mul_hi[0], quo_q[WIDTH-1:1]};
    assign mul_mag    = {mul_rem_nx, mul_quo_nx};
    assign mul_fix    = qneg_q ? -mul_mag : mul_mag;
`else
    // Sign-extend to full width so one unsigned multiply serves both MULT and MULTU
    logic [2*WIDTH-1:0]   a_ext, b_ext, mul_prod;
    logic                 unused_add;

    assign a_ext      = {{WIDTH{op_signed & md_io.a[WIDTH-1]}}, md_io.a};
    assign b_ext      = {{WIDTH{op_signed & md_io.b[WIDTH-1]}}, md_io.b};
    assign mul_prod   = a_ext * b_ext;
    assign unused_add = add_sum[WIDTH];
`endif

    // Next-state and datapath update; flush cancels everything in flight
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        a_d        = a_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        hilo_wd_d  = hilo_wd_q;
        div_zero_d = div_zero_q;

        if (md_io.flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        cnt_d = '0;
                        a_d   = md_io.a;
                        if (op_div) begin
                            rem_d   = '0;
                            quo_d   = a_mag;
                            dvs_d   = b_mag;
                            qneg_d  = op_signed & (md_io.a[WIDTH-1] ^ md_io.b[WIDTH-1]);
                            rneg_d  = op_signed & md_io.a[WIDTH-1];
                            state_d = StDiv;
                        end else if (op_mul) begin
`ifdef MDU_ITER_MULT_EN
                            rem_d   = '0;
                            quo_d   = b_mag;
                            dvs_d   = a_mag;
                            qneg_d  = op_signed & (md_io.a[WIDTH-1] ^ md_io.b[WIDTH-1]);
                            rneg_d  = 1'b0;
                            state_d = StMul;
`else
                            // Product completes at the accept edge, so MUL is passed through
                            hilo_wd_d  = mul_prod;
                            div_zero_d = 1'b0;
                            state_d    = StDone;
`endif
                        end else begin
                            hilo_wd_d  = mt_merge;
                            div_zero_d = 1'b0;
                            state_d    = StDone;
                        end
                    end
                end
                StMul: begin
`ifdef MDU_ITER_MULT_EN
                    rem_d = mul_rem_nx;
                    quo_d = mul_quo_nx;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        hilo_wd_d  = mul_fix;
                        div_zero_d = 1'b0;
                        cnt_d      = '0;
                        state_d    = StDone;
                    end
`else
                    state_d = StIdle;
`endif
                end
                StDiv: begin
                    rem_d = div_rem_nx;
                    quo_d = div_quo_nx;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        // Zero divisor still runs the full loop but reports {a, all-ones}
                        if (dvs_q == '0) begin
                            hilo_wd_d  = {a_q, {WIDTH{1'b1}}};
                            div_zero_d = 1'b1;
                        end else begin
                            hilo_wd_d  = {div_hi, div_lo};
                            div_zero_d = 1'b0;
                        end
                        cnt_d   = '0;
                        state_d = StDone;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and iteration counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand, loop and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            a_q        <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            hilo_wd_q  <= '0;
            div_zero_q <= 1'b0;
        end else begin
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            a_q        <= a_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            hilo_wd_q  <= hilo_wd_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Combinational stall so the requesting instruction holds in its own cycle
    always_comb begin
        md_io.busy = (state_q == StDiv) || (state_q == StMul);
        if (md_io.start && (state_q == StIdle)) begin
`ifdef MDU_ITER_MULT_EN
            md_io.busy = md_io.busy || op_div || op_mul;
`else
            md_io.busy = md_io.busy || op_div;
`endif
        end
    end

    assign md_io.result_valid = (state_q == StDone) & ~md_io.flush;
    assign md_io.hilo_wd      = hilo_wd_q;
    assign md_io.div_zero     = div_zero_q;

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Scoreboard bench for hilo_md_ctrl; honours MDU_ITER_MULT_EN for multiply timing.
`timescale 1ns/1ps
module tb_hilo_md_ctrl;
    localparam int unsigned W = 32;
`ifdef MDU_ITER_MULT_EN
    localparam int MulLat  = 33;
    localparam bit MulBusy = 1'b1;
`else
    localparam int MulLat  = 1;
    localparam bit MulBusy = 1'b0;
`endif
    localparam int DivLat = 33;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    hilo_md_ctrl_if #(.WIDTH(W)) md_if ();

    hilo_md_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .md_io (md_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] hilo;
        logic        dz;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Monitor: every result_valid pulse must match the oldest pending expectation
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && md_if.result_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got hilo_wd %h, want no pulse",
                             md_if.hilo_wd);
                end else begin
                    mon_e = sb.pop_front();
                    check("hilo_wd", md_if.hilo_wd, mon_e.hilo);
                    check("div_zero", 64'(md_if.div_zero), 64'(mon_e.dz));
                    check("valid_cycle", 64'(cyc), 64'(mon_e.due));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    // Present a request in the current cycle T; returns 1 ns into cycle T+1
    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] hl, input bit want_res,
                         input logic [63:0] exp, input logic dz, input int lat,
                         input bit busy_on);
        exp_t e;
        md_if.op     = op;
        md_if.a      = a;
        md_if.b      = b;
        md_if.hilo_i = hl;
        md_if.start  = 1'b1;
        if (want_res) begin
            e.hilo = exp;
            e.dz   = dz;
            e.due  = cyc + lat;
            sb.push_back(e);
        end
        #3 check({name, "_busy_T"}, 64'(md_if.busy), 64'(busy_on));
        @(posedge clk);
        #1 md_if.start = 1'b0;
    endtask

    task automatic expect_busy(input string name, input int n, input bit val);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(name, 64'(md_if.busy), 64'(val));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] hl, input logic [63:0] exp,
                       input logic dz, input int lat, input bit busy_on);
        issue(name, op, a, b, hl, 1'b1, exp, dz, lat, busy_on);
        expect_busy({name, "_busy_run"}, lat - 1, busy_on);
        expect_busy({name, "_busy_done"}, 1, 1'b0);
    endtask

    initial begin
        md_if.start  = 1'b0;
        md_if.op     = 3'b000;
        md_if.a      = '0;
        md_if.b      = '0;
        md_if.hilo_i = '0;
        md_if.flush  = 1'b0;

        #1;
        check("rst_busy", 64'(md_if.busy), 64'd0);
        check("rst_valid", 64'(md_if.result_valid), 64'd0);
        check("rst_hilo", md_if.hilo_wd, 64'd0);
        check("rst_dz", 64'(md_if.div_zero), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Multiplies
        run("mult", 3'b100, 32'hFFFF_FFFE, 32'd3, 64'd0, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0,
            MulLat, MulBusy);
        run("multu", 3'b101, 32'hFFFF_FFFE, 32'd3, 64'd0, 64'h0000_0002_FFFF_FFFA, 1'b0,
            MulLat, MulBusy);

        // Divides
        run("div_neg7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0,
            DivLat, 1'b1);
        run("divu_100_7", 3'b111, 32'd100, 32'd7, 64'd0, 64'h0000_0002_0000_000E, 1'b0,
            DivLat, 1'b1);
        run("divu_by0", 3'b111, 32'd5, 32'd0, 64'd0, 64'h0000_0005_FFFF_FFFF, 1'b1,
            DivLat, 1'b1);
        run("div_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 64'h0000_0000_8000_0000,
            1'b0, DivLat, 1'b1);

        // Moves into HI/LO
        run("mthi", 3'b010, 32'h1234_5678, 32'd0, 64'hAAAA_AAAA_BBBB_BBBB,
            64'h1234_5678_BBBB_BBBB, 1'b0, 1, 1'b0);
        run("mtlo", 3'b011, 32'h1234_5678, 32'd0, 64'hAAAA_AAAA_BBBB_BBBB,
            64'hAAAA_AAAA_1234_5678, 1'b0, 1, 1'b0);

        // Flush mid-divide, then an immediate new divide
        issue("div_flushed", 3'b110, 32'd100, 32'd3, 64'd0, 1'b0, 64'd0, 1'b0, DivLat, 1'b1);
        repeat (9) @(posedge clk);
        #1 md_if.flush = 1'b1;
        @(posedge clk);
        #1 md_if.flush = 1'b0;
        check("flush_busy_low", 64'(md_if.busy), 64'd0);
        run("divu_9_3", 3'b111, 32'd9, 32'd3, 64'd0, 64'h0000_0000_0000_0003, 1'b0,
            DivLat, 1'b1);

        // Flush in DONE suppresses the pulse but the write data is still held
        issue("mthi_flushed", 3'b010, 32'hCAFE_F00D, 32'd0, 64'h1111_1111_2222_2222, 1'b0,
              64'd0, 1'b0, 1, 1'b0);
        md_if.flush = 1'b1;
        #3;
        check("flush_done_valid", 64'(md_if.result_valid), 64'd0);
        check("flush_done_hilo", md_if.hilo_wd, 64'hCAFE_F00D_2222_2222);
        @(posedge clk);
        #1 md_if.flush = 1'b0;

        // Reset mid-divide clears outputs at once and no result follows
        run("divu_by0_b", 3'b111, 32'd77, 32'd0, 64'd0, 64'h0000_004D_FFFF_FFFF, 1'b1,
            DivLat, 1'b1);
        issue("div_reset", 3'b110, 32'd7, 32'd2, 64'd0, 1'b0, 64'd0, 1'b0, DivLat, 1'b1);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst_busy", 64'(md_if.busy), 64'd0);
        check("arst_valid", 64'(md_if.result_valid), 64'd0);
        check("arst_hilo", md_if.hilo_wd, 64'd0);
        check("arst_dz", 64'(md_if.div_zero), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        // Start during busy is ignored; only the divide writes HI/LO
        issue("div_guarded", 3'b110, 32'd100, 32'd7, 64'd0, 1'b1, 64'h0000_0002_0000_000E,
              1'b0, DivLat, 1'b1);
        expect_busy("guard_busy_a", 3, 1'b1);
        md_if.op     = 3'b011;
        md_if.a      = 32'hDEAD_BEEF;
        md_if.hilo_i = 64'h5555_5555_6666_6666;
        md_if.start  = 1'b1;
        @(posedge clk);
        #1 md_if.start = 1'b0;
        expect_busy("guard_busy_b", 28, 1'b1);
        expect_busy("guard_busy_done", 1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("guard_hilo_held", md_if.hilo_wd, 64'h0000_0002_0000_000E);

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
